// File: rtl/sd_loader.sv
// Boot-time bulk copier: reads consecutive bytes from the SD byte interface, packs them
// big-endian into 32-bit words, writes them to RAM from word 0 and holds the CPU in reset until done.
module sd_loader #(
    parameter int unsigned ADDR_W  = 14,
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic [31:0]       sd_addr,
    output logic              sd_read,
    output logic              sd_write,
    output logic [7:0]        sd_write_data,
    input  logic [7:0]        sd_read_data,
    input  logic              sd_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_rst_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_GAP, S_WAIT, S_PACK, S_STORE, S_FIN, S_FAIL
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   REM_ONE = 1;
    localparam logic [23:0]       TMO_ONE = 24'd1;

    state_t              r_state;
    logic [31:0]         r_sd_addr;
    logic [ADDR_W:0]     r_remaining;
    logic [ADDR_W-1:0]   r_word_ptr;
    logic [1:0]          r_byte_idx;
    logic [23:0]         r_tmo;
    logic [31:0]         r_shift;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_data;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic                r_cpu_rst_n;

    logic                w_issue;
    logic                w_tmo_hit;

    // The read request is gated by sd_ready in the same cycle so it can never be seen
    // by the SD interface while it is not ready.
    assign w_issue   = (r_state == S_ISSUE) && sd_ready;
    assign w_tmo_hit = (r_tmo == (TIMEOUT - TMO_ONE));

    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        case (idx)
            2'd0:    w[31:24] = b;
            2'd1:    w[23:16] = b;
            2'd2:    w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sd_addr   <= '0;
            r_remaining <= '0;
            r_word_ptr  <= '0;
            r_byte_idx  <= '0;
            r_tmo       <= '0;
            r_shift     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sd_addr   <= src_addr;
                        r_remaining <= num_words;
                        r_word_ptr  <= '0;
                        r_byte_idx  <= '0;
                        r_tmo       <= '0;
                        r_shift     <= '0;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_cpu_rst_n <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= (num_words == '0) ? S_FIN : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (sd_ready) begin
                        r_tmo   <= '0;
                        r_state <= S_GAP;
                    end else if (w_tmo_hit) begin
                        r_state <= S_FAIL;
                    end else begin
                        r_tmo <= r_tmo + TMO_ONE;
                    end
                end
                // sd_ready may still be the stale pre-request value here, so it is ignored.
                S_GAP: r_state <= S_WAIT;
                S_WAIT: begin
                    if (sd_ready) begin
                        r_shift <= insert_byte(r_shift, r_byte_idx, sd_read_data);
                        r_state <= S_PACK;
                    end else if (w_tmo_hit) begin
                        r_state <= S_FAIL;
                    end else begin
                        r_tmo <= r_tmo + TMO_ONE;
                    end
                end
                S_PACK: begin
                    r_sd_addr <= r_sd_addr + 32'd1;
                    if (r_byte_idx == 2'd3) begin
                        r_byte_idx <= '0;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_word_ptr;
                        r_mem_data <= r_shift;
                        r_state    <= S_STORE;
                    end else begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_STORE: begin
                    r_word_ptr  <= r_word_ptr + PTR_ONE;
                    r_remaining <= r_remaining - REM_ONE;
                    r_state     <= (r_remaining == REM_ONE) ? S_FIN : S_ISSUE;
                end
                S_FIN: begin
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_cpu_rst_n <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_FAIL: begin
                    r_busy  <= 1'b0;
                    r_error <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sd_addr       = r_sd_addr;
    assign sd_read       = w_issue;
    assign sd_write      = 1'b0;
    assign sd_write_data = 8'h00;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_data      = r_mem_data;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign cpu_rst_n     = r_cpu_rst_n;

endmodule

// File: tb/tb_sd_loader.sv
// Bench for sd_loader: behavioural SD byte source plus scoreboards for SD reads and RAM writes.
module tb_sd_loader;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       src_addr = '0;
    logic [ADDR_W:0]   num_words = '0;
    logic [7:0]        sd_read_data = '0;
    logic              sd_ready = 1'b1;
    logic [31:0]       sd_addr;
    logic              sd_read;
    logic              sd_write;
    logic [7:0]        sd_write_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_rst_n;

    sd_loader #(.ADDR_W(ADDR_W), .TIMEOUT(24'd100)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .num_words(num_words),
        .sd_addr(sd_addr), .sd_read(sd_read), .sd_write(sd_write), .sd_write_data(sd_write_data),
        .sd_read_data(sd_read_data), .sd_ready(sd_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic [31:0] src;
        int          n;
        int          lat;
        bit          hold;
        logic        exp_done;
        logic        exp_err;
        logic        exp_cpu;
    } vec_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    vec_t        vecs[4];

    int n_checks = 0;
    int n_errors = 0;

    int          cyc = 0;
    int          last_rd = -100;
    int          rd_cnt = 0;
    int          dead_after = 0;
    int          lat = 0;
    bit          hold = 1'b0;
    int          m_cnt = 0;
    int          hcnt = 0;
    bit          m_drop = 1'b0;
    bit          m_wait = 1'b0;
    logic        m_rdy = 1'b1;
    logic [31:0] m_addr = '0;
    logic        s_rd, s_rdy, s_we;
    wr_t         w_exp;
    logic [31:0] r_exp;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input logic [95:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: actual %0h, required none", name, act);
    endtask

    task automatic push_copy(input logic [31:0] src, input int n);
        logic [31:0] a;
        logic [31:0] d;
        wr_t         w;
        for (int wi = 0; wi < n; wi++) begin
            d = '0;
            for (int b = 0; b < 4; b++) begin
                a = src + 32'(4 * wi + b);
                exp_rd.push_back(a);
                d = {d[23:0], a[7:0]};
            end
            w.addr = wi[ADDR_W-1:0];
            w.data = d;
            exp_wr.push_back(w);
        end
    endtask

    task automatic do_start(input logic [31:0] src, input logic [ADDR_W:0] n);
        @(negedge clk);
        src_addr  = src;
        num_words = n;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic wait_end(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done || error) seen = 1'b1;
        end
        if (!seen) report_fail(name, {done, error});
    endtask

    task automatic wait_reads(input int target, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (rd_cnt >= target) seen = 1'b1;
        end
        if (!seen) report_fail(name, rd_cnt);
    endtask

    // SD byte source (changes on negedge) and scoreboard monitors.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_rdy  = 1'b1;
            m_drop = 1'b0;
            m_wait = 1'b0;
            m_cnt  = 0;
            hcnt   = 0;
        end else begin
            s_rd  = sd_read;
            s_rdy = sd_ready;
            s_we  = mem_we;
            if (m_drop) begin
                m_drop = 1'b0;
                m_rdy  = 1'b0;
                m_wait = 1'b1;
            end else if (m_wait && !((dead_after != 0) && (rd_cnt >= dead_after))) begin
                if (m_cnt == 0) begin
                    sd_read_data = m_addr[7:0];
                    m_rdy  = 1'b1;
                    m_wait = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            if (hcnt != 0) begin
                hcnt--;
                if (hcnt == 0) sd_read_data = m_addr[7:0];
            end
            if (s_rd) begin
                check("rd_while_ready", s_rdy, 1'b1);
                check("rd_with_we", s_we, 1'b0);
                check("rd_spacing", (cyc - last_rd) >= 4, 1'b1);
                if (exp_rd.size() == 0) begin
                    report_fail("rd_unexpected", sd_addr);
                end else begin
                    r_exp = exp_rd.pop_front();
                    check("rd_addr", sd_addr, r_exp);
                end
                m_addr       = sd_addr;
                rd_cnt++;
                last_rd      = cyc;
                sd_read_data = 8'hEE;
                if (hold) hcnt = 2;
                else begin
                    m_drop = 1'b1;
                    m_cnt  = lat;
                end
            end
            if (s_we) begin
                if (exp_wr.size() == 0) begin
                    report_fail("wr_unexpected", {mem_addr, mem_data});
                end else begin
                    w_exp = exp_wr.pop_front();
                    check("wr_addr", mem_addr, w_exp.addr);
                    check("wr_data", mem_data, w_exp.data);
                end
            end
        end
        sd_ready = m_rdy;
    end

    initial begin
        int k;
        bit seen;
        vecs[0] = '{32'h0000_0200, 2, 5, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'hFFFF_FFFE, 1, 2, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_1000, 3, 0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{32'h0ABC_DEF0, 1, 1, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", {sd_read, mem_we, busy, done, error, cpu_rst_n, sd_write, sd_write_data}, '0);
        check("reset_data", {sd_addr, mem_addr, mem_data}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            lat  = vecs[i].lat;
            hold = vecs[i].hold;
            push_copy(vecs[i].src, vecs[i].n);
            do_start(vecs[i].src, vecs[i].n[ADDR_W:0]);
            check($sformatf("v%0d_cpu_held", i), {busy, cpu_rst_n}, 2'b10);
            wait_end($sformatf("v%0d_end", i));
            check($sformatf("v%0d_done", i), done, vecs[i].exp_done);
            check($sformatf("v%0d_error", i), error, vecs[i].exp_err);
            check($sformatf("v%0d_cpu_rst_n", i), cpu_rst_n, vecs[i].exp_cpu);
            check($sformatf("v%0d_busy", i), busy, 1'b0);
            check($sformatf("v%0d_rd_left", i), exp_rd.size(), 0);
            check($sformatf("v%0d_wr_left", i), exp_wr.size(), 0);
        end

        // Zero-length copy: straight to FIN, done two cycles after start.
        hold = 1'b0;
        lat  = 0;
        @(negedge clk);
        src_addr  = 32'h500;
        num_words = '0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("zero_done_early", {done, busy, cpu_rst_n}, 3'b010);
        @(negedge clk);
        #1;
        check("zero_done", {done, busy, cpu_rst_n, error}, 4'b1010);
        repeat (5) @(negedge clk);

        // Second start while busy is ignored; sd_ready held high throughout.
        hold = 1'b1;
        push_copy(32'h10, 2);
        do_start(32'h10, 2);
        repeat (6) @(negedge clk);
        src_addr  = 32'h80;
        num_words = 5;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("busy_end");
        check("busy_done", {done, error, cpu_rst_n}, 3'b101);
        check("busy_rd_left", exp_rd.size(), 0);
        check("busy_wr_left", exp_wr.size(), 0);
        hold = 1'b0;

        // Dead card after the third read: timeout in WAIT.
        lat = 3;
        dead_after = rd_cnt + 3;
        for (int b = 0; b < 3; b++) exp_rd.push_back(32'h300 + 32'(b));
        do_start(32'h300, 1);
        wait_reads(dead_after, "tmo_reads");
        k = 0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            #1;
            k++;
            if (error) seen = 1'b1;
        end
        check("tmo_cycles", k, 103);
        check("tmo_flags", {error, done, cpu_rst_n, busy}, 4'b1000);
        repeat (10) @(negedge clk);
        check("tmo_rd_left", exp_rd.size(), 0);
        check("tmo_wr_left", exp_wr.size(), 0);
        dead_after = 0;
        repeat (10) @(negedge clk);

        // Reset mid-word after two bytes, then a fresh one-word copy.
        lat = 2;
        for (int b = 0; b < 3; b++) exp_rd.push_back(32'h40 + 32'(b));
        k = rd_cnt + 3;
        do_start(32'h40, 1);
        wait_reads(k, "abort_reads");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ctrl", {sd_read, mem_we, busy, done, error, cpu_rst_n}, '0);
        check("abort_data", {sd_addr, mem_addr, mem_data}, '0);
        exp_rd.delete();
        exp_wr.delete();
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        push_copy(32'h0, 1);
        do_start(32'h0, 1);
        wait_end("fresh_end");
        check("fresh_done", {done, error, cpu_rst_n}, 3'b101);
        check("fresh_rd_left", exp_rd.size(), 0);
        check("fresh_wr_left", exp_wr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sd_loader.md
Name: sd_loader

Overview:
- Boot-time bulk copier. Sits upstream of the SD card byte interface (sd_read / sd_read_data / sd_ready) and drives its request side.
- On start, reads NUM_WORDS x 4 consecutive bytes beginning at a byte address.
- Packs each 4 bytes big-endian into a 32-bit word and writes the words to instruction/data RAM from word address 0.
- Holds the CPU in reset until done, with a per-byte timeout for dead cards.

Parameters:
ADDR_W, 14, RAM word-address width
TIMEOUT, 24'd10_000_000, max cycles waiting for sd_ready per byte before error

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; accepted only in IDLE
src_addr  in  32  first SD byte address; sampled on start
num_words  in  ADDR_W+1  words to copy (0..2^ADDR_W); sampled on start
sd_addr  out  32  byte address to SD interface
sd_read  out  1  one-cycle read request
sd_write  out  1  tied 0
sd_write_data  out  8  tied 0
sd_read_data  in  8  byte returned by SD interface
sd_ready  in  1  SD interface idle / data valid
mem_we  out  1  one-cycle RAM write strobe
mem_addr  out  ADDR_W  RAM word address
mem_data  out  32  packed word
busy  out  1  copy in progress
done  out  1  sticky, set at successful completion
error  out  1  sticky, set on timeout
cpu_rst_n  out  1  low until done

Behaviour:
Reset (async, rst_n=0):
- state=IDLE.
- Outputs: sd_read=0, mem_we=0, busy=0, done=0, error=0, cpu_rst_n=0.
- sd_addr=0, mem_addr=0, mem_data=0.
- Internal counters cleared.
- Reset mid-copy aborts immediately. No further sd_read is issued. A partially packed word is discarded.

States: IDLE, ISSUE, GAP, WAIT, PACK, STORE, FIN, FAIL.
- IDLE:
  - start=1 -> latch src_addr into sd_addr, num_words into remaining, byte_idx=0, word_ptr=0, clear done/error, busy=1.
  - num_words=0 -> FIN; otherwise -> ISSUE.
  - start while busy is ignored.
- ISSUE:
  - Wait until sd_ready=1, then assert sd_read for exactly 1 cycle with current sd_addr, clear the timeout counter -> GAP.
  - The timeout counter also runs while waiting here.
- GAP: 1 cycle. sd_ready is not sampled (the SD interface may still show stale ready) -> WAIT.
- WAIT:
  - sd_ready=1 -> capture sd_read_data into shift reg, bits [31-8*byte_idx -: 8] -> PACK.
  - Counter reaching TIMEOUT-1 -> FAIL.
- PACK:
  - sd_addr += 1 (32-bit wrap permitted, no flag).
  - byte_idx<3 -> byte_idx++ -> ISSUE.
  - byte_idx==3 -> byte_idx=0 -> STORE.
- STORE:
  - mem_we=1 for 1 cycle; mem_addr=word_ptr; mem_data=packed word (byte at lowest SD address in [31:24]).
  - word_ptr++, remaining--.
  - remaining becomes 0 -> FIN, else -> ISSUE.
- FIN:
  - busy=0, done=1, cpu_rst_n=1 from the next cycle -> IDLE.
  - done and cpu_rst_n stay high until the next start or reset.
  - A new start drops cpu_rst_n to 0 again.
- FAIL: busy=0, error=1, cpu_rst_n remains 0 -> IDLE.

Widths and limits:
- word_ptr is ADDR_W bits. num_words=2^ADDR_W fills RAM exactly; the final mem_addr is 2^ADDR_W-1 and there is no wrap write.
- num_words above 2^ADDR_W is impossible by width.

Latency:
- Per byte = ISSUE wait + 1 (sd_read) + 1 (GAP) + WAIT cycles + 1 (PACK).
- Per word adds 1 STORE cycle.
- Handshake invariants: sd_read and mem_we are never high in the same cycle. sd_read is never asserted while sd_ready=0.

Test Plan:
- Reset, then start with src_addr=0x200, num_words=2, model returns byte = addr[7:0] after 5 cycles -> mem_we at addr 0 data 0x00010203, addr 1 data 0x04050607; sd_read addresses 0x200..0x207 in order; done=1, cpu_rst_n=1.
- Start with num_words=0 -> no sd_read, no mem_we; done=1 two cycles after start.
- Model holds sd_ready=0 forever after 3rd byte, TIMEOUT=100 -> error=1 after 100 cycles in WAIT; cpu_rst_n stays 0; exactly 2 bytes consumed, no mem_we.
- Deassert rst_n mid-word (after 2 bytes) -> all outputs 0 within the same cycle; a fresh start from 0x0, num_words=1 writes the correct word at addr 0.
- Second start pulse during busy, plus sd_ready held high continuously -> ignored; model checks one sd_read per byte, never back-to-back, and a GAP cycle between each sd_read and the byte capture.
- src_addr=0xFFFFFFFE, num_words=1 -> sd_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; word written to addr 0.
